// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file, r0 hardwired to zero, with write bypass, pending scoreboard and post-reset clear.
// Latency: reads and rd_pend are combinational; writes and pending updates take effect on the next rising edge; clear takes NREGS-1 edges.
// Backpressure: none; writes and issues are accepted every RUN cycle and ignored while o_busy is high.
module regfile_mp #(
    parameter  int WIDTH  = 16,
    parameter  int NREGS  = 8,
    parameter  int NREAD  = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_waddr,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic [NREAD*AW-1:0]    i_raddr,
    output logic [NREAD*WIDTH-1:0] o_rdata,
    output logic [NREAD-1:0]       o_rd_pend,
    input  logic                   i_iss_valid,
    input  logic [AW-1:0]          i_iss_addr,
    output logic                   o_busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;
    logic [WIDTH-1:0] r_mem [NREGS];

    logic w_run;
    logic w_clr_en;
    logic w_wr_en;

    assign w_run    = (r_state == ST_RUN);
    assign w_clr_en = (r_state == ST_CLEAR);
    // r0 is never stored: reads of address 0 are forced to zero at the port mux
    assign w_wr_en  = w_run && i_we && (i_waddr != '0);
    assign o_busy   = (r_state == ST_CLEAR);

    // Clear sequencer next state: walk cnt from 1 to NREGS-1, then hand over to RUN
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == ST_CLEAR) begin
            w_cnt_nxt = r_cnt + AW'(1);
            if (r_cnt == LAST_IDX) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    // Sequencer state register; reset restarts the clear walk at entry 1
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Array write: clear walk zeroes one entry per edge, otherwise the writeback port; nothing is written on a reset edge
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (w_clr_en) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_en) begin
                r_mem[i_waddr] <= i_wdata;
            end
        end
    end

    // Pending scoreboard next state: writeback clears, issue sets, and a same-edge issue wins over the clear
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_run) begin
            if (i_we) begin
                w_pend_nxt[i_waddr] = 1'b0;
            end
            if (i_iss_valid && (i_iss_addr != '0)) begin
                w_pend_nxt[i_iss_addr] = 1'b1;
            end
        end
    end

    // Pending scoreboard register; bit 0 is never set so r0 never reports a hazard
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Independent read ports: zero during clear and for r0, forwarded write data ahead of the array
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;

        assign w_ra  = i_raddr[gi*AW +: AW];
        assign w_hit = (BYPASS == 1) && i_we && (i_waddr == w_ra);

        assign o_rdata[gi*WIDTH +: WIDTH] = (!w_run || (w_ra == '0)) ? '0 :
                                            w_hit                    ? i_wdata :
                                                                       r_mem[w_ra];

        // A forwarded producer resolves the hazard in the same cycle, so the flag is masked
        assign o_rd_pend[gi] = w_run && r_pend[w_ra] && !w_hit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (default, no-bypass and wide/3-port instances).
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 1 time unit later.
// Backpressure: none; the bench drives every cycle and bounds every loop by a fixed edge count.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: defaults (WIDTH 16, NREGS 8, NREAD 2, BYPASS 1)
    logic        a_we, a_iss_valid, a_busy;
    logic [2:0]  a_waddr, a_iss_addr;
    logic [15:0] a_wdata;
    logic [5:0]  a_raddr;
    logic [31:0] a_rdata;
    logic [1:0]  a_rd_pend;

    // Instance B: BYPASS 0
    logic        b_we, b_iss_valid, b_busy;
    logic [2:0]  b_waddr, b_iss_addr;
    logic [15:0] b_wdata;
    logic [5:0]  b_raddr;
    logic [31:0] b_rdata;
    logic [1:0]  b_rd_pend;

    // Instance C: WIDTH 32, NREGS 16, NREAD 3
    logic        c_we, c_iss_valid, c_busy;
    logic [3:0]  c_waddr, c_iss_addr;
    logic [31:0] c_wdata;
    logic [11:0] c_raddr;
    logic [95:0] c_rdata;
    logic [2:0]  c_rd_pend;

    regfile_mp dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(a_we), .i_waddr(a_waddr), .i_wdata(a_wdata),
        .i_raddr(a_raddr), .o_rdata(a_rdata), .o_rd_pend(a_rd_pend),
        .i_iss_valid(a_iss_valid), .i_iss_addr(a_iss_addr), .o_busy(a_busy)
    );

    regfile_mp #(.BYPASS(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(b_we), .i_waddr(b_waddr), .i_wdata(b_wdata),
        .i_raddr(b_raddr), .o_rdata(b_rdata), .o_rd_pend(b_rd_pend),
        .i_iss_valid(b_iss_valid), .i_iss_addr(b_iss_addr), .o_busy(b_busy)
    );

    regfile_mp #(.WIDTH(32), .NREGS(16), .NREAD(3)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(c_we), .i_waddr(c_waddr), .i_wdata(c_wdata),
        .i_raddr(c_raddr), .o_rdata(c_rdata), .o_rd_pend(c_rd_pend),
        .i_iss_valid(c_iss_valid), .i_iss_addr(c_iss_addr), .o_busy(c_busy)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];
    logic [15:0] sh [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst_n = 1'b0;
        tick();
        tick();
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        e = exp_q.pop_front(); total++; if (32'(a_busy) !== e) begin bad++; $display("FAIL reset_busy got=%h exp=%h", a_busy, e); end
        e = exp_q.pop_front(); total++; if (a_rdata !== e) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", a_rdata, e); end
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend) !== e) begin bad++; $display("FAIL reset_rd_pend got=%h exp=%h", a_rd_pend, e); end
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp_q.push_back((k < 7) ? 32'd1 : 32'd0);
            exp_q.push_back((k < 15) ? 32'd1 : 32'd0);
            e = exp_q.pop_front(); total++; if (32'(a_busy) !== e) begin bad++; $display("FAIL clear_busy_a edge=%0d got=%h exp=%h", k, a_busy, e); end
            e = exp_q.pop_front(); total++; if (32'(c_busy) !== e) begin bad++; $display("FAIL clear_busy_c edge=%0d got=%h exp=%h", k, c_busy, e); end
        end
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); total++; if (32'(b_busy) !== e) begin bad++; $display("FAIL clear_busy_b got=%h exp=%h", b_busy, e); end
        for (int r = 0; r < 8; r++) begin
            a_raddr = {3'(r), 3'(r)};
            exp_q.push_back(32'd0);
            #1;
            e = exp_q.pop_front(); total++; if (a_rdata !== e) begin bad++; $display("FAIL cleared_read r%0d got=%h exp=%h", r, a_rdata, e); end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        a_we = 1'b1; a_waddr = 3'd3; a_wdata = 16'hBEEF;
        tick();
        a_we = 1'b0; a_raddr = {3'd3, 3'd3};
        exp_q.push_back(32'hBEEF); exp_q.push_back(32'hBEEF);
        #1;
        e = exp_q.pop_front(); total++; if (32'(a_rdata[15:0]) !== e) begin bad++; $display("FAIL wr_rd_p0 got=%h exp=%h", a_rdata[15:0], e); end
        e = exp_q.pop_front(); total++; if (32'(a_rdata[31:16]) !== e) begin bad++; $display("FAIL wr_rd_p1 got=%h exp=%h", a_rdata[31:16], e); end
        a_we = 1'b1; a_waddr = 3'd0; a_wdata = 16'h1234; a_raddr = {3'd0, 3'd0};
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); total++; if (a_rdata !== e) begin bad++; $display("FAIL r0_bypass got=%h exp=%h", a_rdata, e); end
        tick();
        a_we = 1'b0;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); total++; if (a_rdata !== e) begin bad++; $display("FAIL r0_after got=%h exp=%h", a_rdata, e); end
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        a_we = 1'b1; a_waddr = 3'd5; a_wdata = 16'h0001;
        b_we = 1'b1; b_waddr = 3'd5; b_wdata = 16'h0001;
        tick();
        a_wdata = 16'hA5A5; b_wdata = 16'hA5A5;
        a_raddr = {3'd3, 3'd5}; b_raddr = {3'd3, 3'd5};
        exp_q.push_back(32'hA5A5); exp_q.push_back(32'hBEEF); exp_q.push_back(32'h0001);
        #1;
        e = exp_q.pop_front(); total++; if (32'(a_rdata[15:0]) !== e) begin bad++; $display("FAIL bypass_a_p0 got=%h exp=%h", a_rdata[15:0], e); end
        e = exp_q.pop_front(); total++; if (32'(a_rdata[31:16]) !== e) begin bad++; $display("FAIL bypass_a_p1 got=%h exp=%h", a_rdata[31:16], e); end
        e = exp_q.pop_front(); total++; if (32'(b_rdata[15:0]) !== e) begin bad++; $display("FAIL nobypass_b_p0 got=%h exp=%h", b_rdata[15:0], e); end
        tick();
        a_we = 1'b0; b_we = 1'b0;
        exp_q.push_back(32'hA5A5);
        #1;
        e = exp_q.pop_front(); total++; if (32'(b_rdata[15:0]) !== e) begin bad++; $display("FAIL nobypass_b_after got=%h exp=%h", b_rdata[15:0], e); end
    endtask

    task automatic test_scoreboard();
        logic [31:0] e;
        a_iss_valid = 1'b1; a_iss_addr = 3'd2; a_raddr = {3'd0, 3'd2};
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend) !== e) begin bad++; $display("FAIL pend_before_edge got=%h exp=%h", a_rd_pend, e); end
        tick();
        a_iss_valid = 1'b0;
        exp_q.push_back(32'b01);
        #1;
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend) !== e) begin bad++; $display("FAIL pend_set got=%h exp=%h", a_rd_pend, e); end
        a_we = 1'b1; a_waddr = 3'd2; a_wdata = 16'h2222;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend) !== e) begin bad++; $display("FAIL pend_masked got=%h exp=%h", a_rd_pend, e); end
        tick();
        a_we = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'h2222);
        #1;
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend) !== e) begin bad++; $display("FAIL pend_cleared got=%h exp=%h", a_rd_pend, e); end
        e = exp_q.pop_front(); total++; if (32'(a_rdata[15:0]) !== e) begin bad++; $display("FAIL pend_wr_data got=%h exp=%h", a_rdata[15:0], e); end
        a_iss_valid = 1'b1; a_iss_addr = 3'd4; a_we = 1'b1; a_waddr = 3'd4; a_wdata = 16'h4444;
        tick();
        a_iss_valid = 1'b1; a_iss_addr = 3'd0; a_we = 1'b0;
        tick();
        a_iss_valid = 1'b0; a_raddr = {3'd4, 3'd0};
        exp_q.push_back(32'b10);
        #1;
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend) !== e) begin bad++; $display("FAIL pend_set_wins_r0_zero got=%h exp=%h", a_rd_pend, e); end
        b_iss_valid = 1'b1; b_iss_addr = 3'd2;
        tick();
        b_iss_valid = 1'b0; b_we = 1'b1; b_waddr = 3'd2; b_wdata = 16'h2222; b_raddr = {3'd2, 3'd2};
        exp_q.push_back(32'b11); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); total++; if (32'(b_rd_pend) !== e) begin bad++; $display("FAIL nobypass_pend_kept got=%h exp=%h", b_rd_pend, e); end
        e = exp_q.pop_front(); total++; if (b_rdata !== e) begin bad++; $display("FAIL nobypass_old_data got=%h exp=%h", b_rdata, e); end
        tick();
        b_we = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'h2222_2222);
        #1;
        e = exp_q.pop_front(); total++; if (32'(b_rd_pend) !== e) begin bad++; $display("FAIL nobypass_pend_clr got=%h exp=%h", b_rd_pend, e); end
        e = exp_q.pop_front(); total++; if (b_rdata !== e) begin bad++; $display("FAIL nobypass_new_data got=%h exp=%h", b_rdata, e); end
    endtask

    task automatic test_wide();
        logic [31:0] e;
        c_we = 1'b1; c_waddr = 4'd15; c_wdata = 32'hDEAD_BEEF;
        tick();
        c_waddr = 4'd9; c_wdata = 32'h1234_5678;
        tick();
        c_we = 1'b0; c_raddr = {4'd0, 4'd9, 4'd15};
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h1234_5678); exp_q.push_back(32'd0);
        #1;
        for (int p = 0; p < 3; p++) begin
            e = exp_q.pop_front(); total++; if (c_rdata[p*32 +: 32] !== e) begin bad++; $display("FAIL wide_rd p%0d got=%h exp=%h", p, c_rdata[p*32 +: 32], e); end
        end
        c_we = 1'b1; c_waddr = 4'd9; c_wdata = 32'hCAFE_F00D; c_raddr = {4'd15, 4'd9, 4'd9};
        exp_q.push_back(32'hCAFE_F00D); exp_q.push_back(32'hCAFE_F00D); exp_q.push_back(32'hDEAD_BEEF);
        #1;
        for (int p = 0; p < 3; p++) begin
            e = exp_q.pop_front(); total++; if (c_rdata[p*32 +: 32] !== e) begin bad++; $display("FAIL wide_bypass p%0d got=%h exp=%h", p, c_rdata[p*32 +: 32], e); end
        end
        tick();
        c_we = 1'b0; c_iss_valid = 1'b1; c_iss_addr = 4'd7;
        tick();
        c_iss_valid = 1'b0; c_raddr = {4'd7, 4'd9, 4'd7};
        exp_q.push_back(32'b101);
        #1;
        e = exp_q.pop_front(); total++; if (32'(c_rd_pend) !== e) begin bad++; $display("FAIL wide_pend got=%h exp=%h", c_rd_pend, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic [2:0]  ra;
        sh = '{16'h0, 16'h0, 16'h2222, 16'hBEEF, 16'h4444, 16'hA5A5, 16'h0, 16'h0};
        a_iss_valid = 1'b0;
        for (int n = 0; n < 24; n++) begin
            a_we    = 1'($urandom_range(0, 1));
            a_waddr = 3'($urandom_range(0, 7));
            a_wdata = 16'($urandom);
            a_raddr = 6'($urandom_range(0, 63));
            for (int p = 0; p < 2; p++) begin
                ra = a_raddr[p*3 +: 3];
                if (ra == 3'd0)                     exp_q.push_back(32'd0);
                else if (a_we && (a_waddr == ra))   exp_q.push_back(32'(a_wdata));
                else                                exp_q.push_back(32'(sh[ra]));
            end
            #1;
            for (int p = 0; p < 2; p++) begin
                e = exp_q.pop_front(); total++; if (32'(a_rdata[p*16 +: 16]) !== e) begin bad++; $display("FAIL b2b n=%0d p%0d got=%h exp=%h", n, p, a_rdata[p*16 +: 16], e); end
            end
            if (a_we && (a_waddr != 3'd0)) sh[a_waddr] = a_wdata;
            tick();
        end
        a_we = 1'b0;
    endtask

    task automatic test_midrun_reset();
        logic [31:0] e;
        a_we = 1'b1; a_waddr = 3'd1; a_wdata = 16'h00FF;
        tick();
        a_we = 1'b0; a_iss_valid = 1'b1; a_iss_addr = 3'd1;
        tick();
        a_iss_valid = 1'b0; a_raddr = {3'd4, 3'd1};
        exp_q.push_back(32'h00FF); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); total++; if (32'(a_rdata[15:0]) !== e) begin bad++; $display("FAIL pre_rst_r1 got=%h exp=%h", a_rdata[15:0], e); end
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend[0]) !== e) begin bad++; $display("FAIL pre_rst_pend1 got=%h exp=%h", a_rd_pend[0], e); end
        rst_n = 1'b0; a_we = 1'b1; a_waddr = 3'd3; a_wdata = 16'h7777;
        tick();
        rst_n = 1'b1;
        a_we = 1'b1; a_waddr = 3'd6; a_wdata = 16'hFFFF; a_iss_valid = 1'b1; a_iss_addr = 3'd6;
        a_raddr = {3'd6, 3'd1};
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); total++; if (32'(a_busy) !== e) begin bad++; $display("FAIL rst_busy got=%h exp=%h", a_busy, e); end
        e = exp_q.pop_front(); total++; if (a_rdata !== e) begin bad++; $display("FAIL rst_rdata got=%h exp=%h", a_rdata, e); end
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend) !== e) begin bad++; $display("FAIL rst_pend got=%h exp=%h", a_rd_pend, e); end
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_q.push_back((k < 7) ? 32'd1 : 32'd0);
            e = exp_q.pop_front(); total++; if (32'(a_busy) !== e) begin bad++; $display("FAIL reclear_busy edge=%0d got=%h exp=%h", k, a_busy, e); end
            if (k < 7) begin
                exp_q.push_back(32'd0);
                e = exp_q.pop_front(); total++; if (a_rdata !== e) begin bad++; $display("FAIL clear_window_rdata edge=%0d got=%h exp=%h", k, a_rdata, e); end
            end
        end
        a_we = 1'b0; a_iss_valid = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); total++; if (a_rdata !== e) begin bad++; $display("FAIL post_clear_r6_r1 got=%h exp=%h", a_rdata, e); end
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend) !== e) begin bad++; $display("FAIL post_clear_pend_r6_r1 got=%h exp=%h", a_rd_pend, e); end
        a_raddr = {3'd3, 3'd4};
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); total++; if (a_rdata !== e) begin bad++; $display("FAIL post_clear_r3_r4 got=%h exp=%h", a_rdata, e); end
        e = exp_q.pop_front(); total++; if (32'(a_rd_pend) !== e) begin bad++; $display("FAIL post_clear_pend_r3_r4 got=%h exp=%h", a_rd_pend, e); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0; a_iss_valid = 1'b0; a_iss_addr = '0;
        b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0; b_iss_valid = 1'b0; b_iss_addr = '0;
        c_we = 1'b0; c_waddr = '0; c_wdata = '0; c_raddr = '0; c_iss_valid = 1'b0; c_iss_addr = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_wide();
        test_back_to_back();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the pipelined RiSC-16 datapath, with register 0 hardwired to zero. It adds write-to-read bypass, a per-register pending scoreboard for hazard detection, and a post-reset clear sequencer that zeroes the array one entry per cycle. It sits between decode (reads, issue marking) and writeback (writes).

## Interface

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 8, number of registers; a power of two, at least 2. AW = clog2(NREGS), derived, not overridable.
- NREAD, 2, number of read ports, at least 1.
- BYPASS, 1, enables write-data forwarding to reads when set to 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr  in  NREAD*AW  read addresses, flat; port i uses bits [i*AW +: AW].
- rdata  out  NREAD*WIDTH  read data, flat; port i uses bits [i*WIDTH +: WIDTH]. Combinational.
- rd_pend  out  NREAD  pending flag of each read address. Combinational.
- iss_valid  in  1  marks iss_addr as having an in-flight producer.
- iss_addr  in  AW  destination being issued.
- busy  out  1  high while the clear sequence runs.

## Operation

- State machine has two states: CLEAR and RUN; a counter cnt (AW bits).
- Rising edge with rst_n = 0:
  - state goes to CLEAR; cnt = 1; all pending bits are cleared.
  - Array contents are not written.
- CLEAR, rst_n = 1:
  - Each edge writes 0 to reg[cnt] and increments cnt.
  - The edge that clears reg[NREGS-1] moves the state to RUN.
  - we and iss_valid are ignored.
  - All rdata read 0; all rd_pend read 0.
  - busy = (state == CLEAR).
- RUN, write:
  - we = 1 with waddr != 0 writes wdata to reg[waddr] on the edge.
  - Writes to address 0 are discarded.
- RUN, read:
  - Port i returns 0 if raddr_i = 0.
  - Otherwise, if BYPASS = 1 and we = 1 and waddr = raddr_i, it returns wdata.
  - Otherwise it returns reg[raddr_i].
  - All ports are independent; any ports may address the same register.
- Scoreboard, RUN only:
  - pend[iss_addr] is set on the edge when iss_valid = 1 and iss_addr != 0.
  - pend[waddr] is cleared on the edge when we = 1.
  - Same address set and cleared on one edge: set wins, since a new producer supersedes the old one.
  - pend[0] is constantly 0.
- rd_pend[i]:
  - Equals pend[raddr_i].
  - Forced to 0 when BYPASS = 1, we = 1 and waddr = raddr_i, because the data is forwarded that cycle.
- Reset mid-operation (any state): takes effect on the next rising edge.
  - Pending bits are lost.
  - The clear sequence restarts at cnt = 1.
  - An in-progress write on that edge is dropped.

## Timing

- Reset values: busy = 1; rdata = 0; rd_pend = 0; pend = 0; state = CLEAR.
- Clear duration: exactly NREGS-1 rising edges with rst_n = 1. For NREGS = 8, busy falls after the 7th such edge.
- Write latency: one edge. Data written on edge N is readable from the array after edge N. With BYPASS = 1 it is also visible combinationally during the write cycle.
- Pending: set or clear is visible on rd_pend in the cycle after the edge. Bypass masking applies in the same cycle.
- No handshake on writes or issues; both are accepted every cycle in RUN.

## Test plan

- Reset: hold rst_n = 0 for 2 edges, release; expect busy = 1 for 7 edges (NREGS = 8), then busy = 0. Read all registers: all 0.
- Write/read: write 16'hBEEF to r3. Next cycle, raddr port0 = 3 and port1 = 3: both read 16'hBEEF. Write 16'h1234 to r0: r0 still reads 0.
- Bypass: with reg[5] = 16'h0001, drive we = 1, waddr = 5, wdata = 16'hA5A5, raddr port0 = 5 in the same cycle. Expect rdata0 = 16'hA5A5 before the edge. Repeat with BYPASS = 0: expect 16'h0001.
- Scoreboard: issue r2. Next cycle rd_pend for r2 = 1. Write r2: rd_pend = 0 during the write cycle (BYPASS = 1) and stays 0 after. Issue r4 and write r4 on the same edge: pend[4] = 1 afterwards.
- Clear window: during busy, drive we = 1, waddr = 6, wdata = 16'hFFFF and iss_valid = 1, iss_addr = 6. After busy falls, r6 = 0 and rd_pend = 0.
- Mid-run reset: with r1 = 16'h00FF and pend[1] = 1, pulse rst_n = 0 for one edge. Expect busy re-asserts for 7 edges, then r1 = 0 and rd_pend for r1 = 0. Also run with WIDTH = 32, NREGS = 16, NREAD = 3: expect a 15-edge clear and independent ports.
